// File: rtl/fibonacci_bcd_display.sv
// Converts each new fibonacci_series term to packed BCD (serial double-dabble,
// one bit per clock) and drives a multiplexed active-low 7-segment display.
module fibonacci_bcd_display #(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int SCAN_DIV      = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      fibonacci_series,
  input  logic                  led_on,
  output logic [4*DIGITS-1:0]   bcd_value,
  output logic                  bcd_valid,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int SR_W   = 4 * DIGITS + WIDTH;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic                start;
  logic [SR_W-1:0]     shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WIDTH-1:0]    last_value;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[WIDTH+4*i +: 4] >= 4'd5)
        t[WIDTH+4*i +: 4] = t[WIDTH+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: if (fibonacci_series != last_value) begin
        start      = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (bit_cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      last_value <= '0;
      bcd_value  <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shift_reg  <= {{(4*DIGITS){1'b0}}, fibonacci_series};
          last_value <= fibonacci_series;
          bit_cnt    <= '0;
        end
        SHIFT: begin
          shift_reg <= dabble_step(shift_reg);
          bit_cnt   <= bit_cnt + 1'b1;
        end
        DONE: begin
          bcd_value <= shift_reg[SR_W-1 -: 4*DIGITS];
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic              led_on_reg;
  logic [3:0]        cur_nibble;
  logic              blank;
  logic [6:0]        seg_next;

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    cur_nibble = 4'd0;
    blank      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(digit_idx) == i) begin
        cur_nibble = bcd_value[4*i +: 4];
        blank      = BLANK_LEADING && (i != 0) && ((bcd_value >> (4*i)) == '0);
      end
    end
    seg_next = blank ? 7'b1111111 : seg_code(cur_nibble);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      led_on_reg <= 1'b0;
      seg_n      <= 7'b1111111;
      dp_n       <= 1'b1;
      an_n       <= '1;
    end else begin
      led_on_reg <= led_on;
      seg_n      <= seg_next;
      dp_n       <= !(led_on_reg && (digit_idx == '0));
      an_n       <= ~(DIGITS'(1) << digit_idx);
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_bcd_display.sv
// Directed bench for fibonacci_bcd_display: conversion table, scan/blanking,
// decimal point, mid-conversion input change and reset corner cases.
module tb_fibonacci_bcd_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] fibonacci_series;
  logic        led_on;
  logic [19:0] bcd_value;
  logic        bcd_valid;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [4:0]  an_n;

  fibonacci_bcd_display #(
    .WIDTH(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fibonacci_series(fibonacci_series),
    .led_on(led_on), .bcd_value(bcd_value), .bcd_valid(bcd_valid),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [19:0] bcd;
    int          ndig;   // significant digits; digits at and above this are blank
  } vec_t;

  vec_t       vecs [6];
  logic [6:0] seg_tab [10];
  logic [4:0] one = 5'b00001;

  int  n_checks   = 0;
  int  n_fail     = 0;
  int  pulse_cnt  = 0;
  bit  prev_valid = 1'b0;

  // Ticks from applying a new input to seeing bcd_valid: one edge to reach
  // the sampling edge E0, then 17 edges of conversion.
  localparam int LAT = 18;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (prev_valid) check("valid_one_cycle", {31'd0, bcd_valid}, 32'd0);
    prev_valid = bcd_valid;
    if (bcd_valid) pulse_cnt++;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bcd_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_display(input logic [19:0] exp_bcd, input int ndig, input bit led);
    logic [4:0] seen;
    logic [6:0] exp_seg;
    int idx;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      idx = -1;
      for (int i = 0; i < 5; i++) if (an_n == ~(one << i)) idx = i;
      check("an_one_hot", {31'd0, idx >= 0}, 32'd1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        exp_seg = (idx != 0 && idx >= ndig) ? 7'b1111111 : seg_tab[exp_bcd[4*idx +: 4]];
        check($sformatf("seg_digit%0d", idx), {25'd0, seg_n}, {25'd0, exp_seg});
        check($sformatf("dp_digit%0d", idx), {31'd0, dp_n}, {31'd0, !(led && idx == 0)});
      end
    end
    check("all_digits_scanned", {27'd0, seen}, 32'h1F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, exp_idx;
    logic [15:0] gen_seq [6];
    logic [15:0] prev;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{16'd46368, 20'h46368, 5};
    vecs[1] = '{16'd233,   20'h00233, 3};
    vecs[2] = '{16'd7,     20'h00007, 1};
    vecs[3] = '{16'd65535, 20'h65535, 5};
    vecs[4] = '{16'd1000,  20'h01000, 4};
    vecs[5] = '{16'd10,    20'h00010, 2};
    gen_seq = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};

    // Reset for 20 cycles with input 0.
    reset_n = 1'b0;
    fibonacci_series = 16'd0;
    led_on = 1'b0;
    #1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 19) begin
        check("rst_an_n", {27'd0, an_n}, 32'h1F);
        check("rst_seg_n", {25'd0, seg_n}, 32'h7F);
        check("rst_dp_n", {31'd0, dp_n}, 32'd1);
        check("rst_bcd_value", {12'd0, bcd_value}, 32'd0);
        check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
      end
    end
    reset_n = 1'b1;

    // Scan order and blanking of a zero value; input 0 must not convert.
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_idx = ((k - 1) / 4) % 5;
      check("scan_an_n", {27'd0, an_n}, {27'd0, ~(one << exp_idx)});
      check("zero_seg_n", {25'd0, seg_n}, (exp_idx == 0) ? 32'h40 : 32'h7F);
    end
    check("no_valid_for_zero", pulse_cnt, 0);

    // Conversion table.
    for (int v = 0; v < 6; v++) begin
      fibonacci_series = vecs[v].value;
      wait_valid(lat);
      check($sformatf("latency_%0d", vecs[v].value), lat, LAT);
      check($sformatf("bcd_%0d", vecs[v].value), {12'd0, bcd_value}, {12'd0, vecs[v].bcd});
      check_display(vecs[v].bcd, vecs[v].ndig, 1'b0);
    end

    // Decimal point follows led_on on digit 0 only (two register stages).
    led_on = 1'b1;
    tick();
    tick();
    check_display(20'h00010, 2, 1'b1);
    led_on = 1'b0;
    tick();
    tick();

    // 13, then 21 three cycles later while the first conversion is shifting.
    p0 = pulse_cnt;
    fibonacci_series = 16'd13;
    tick(); tick(); tick();
    fibonacci_series = 16'd21;
    wait_valid(lat);
    check("mid_first_latency", lat, LAT - 3);
    check("mid_first_bcd", {12'd0, bcd_value}, 32'h00013);
    wait_valid(lat);
    check("mid_second_gap", lat, 18);
    check("mid_second_bcd", {12'd0, bcd_value}, 32'h00021);
    repeat (40) tick();
    check("mid_pulse_count", pulse_cnt - p0, 2);

    // Generator-like sequence with a repeated value.
    p0 = pulse_cnt;
    prev = 16'd21;
    for (int s = 0; s < 6; s++) begin
      fibonacci_series = gen_seq[s];
      if (gen_seq[s] != prev) begin
        wait_valid(lat);
        check($sformatf("gen_latency_%0d", s), lat, LAT);
        check($sformatf("gen_bcd_%0d", s), {12'd0, bcd_value}, {16'd0, gen_seq[s]});
      end else begin
        repeat (30) tick();
      end
      prev = gen_seq[s];
    end
    check("gen_pulse_count", pulse_cnt - p0, 5);

    // Reset five edges into a conversion of 610.
    fibonacci_series = 16'd610;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_bcd_value", {12'd0, bcd_value}, 32'd0);
    check("midrst_an_n", {27'd0, an_n}, 32'h1F);
    check("midrst_seg_n", {25'd0, seg_n}, 32'h7F);
    p0 = pulse_cnt;
    repeat (3) tick();
    check("midrst_hold_an_n", {27'd0, an_n}, 32'h1F);
    check("midrst_hold_valid", pulse_cnt - p0, 0);
    reset_n = 1'b1;
    wait_valid(lat);
    check("postrst_latency", lat, LAT);
    check("postrst_bcd", {12'd0, bcd_value}, 32'h00610);
    check("postrst_pulse_count", pulse_cnt - p0, 1);
    check_display(20'h00610, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
